// File: rtl/guess_row_sequencer_if.sv
// Keystroke, evaluator, board-read and status bundle for guess_row_sequencer.
// slave is the sequencer's view; master is the driving/observing side.
interface guess_row_sequencer_if #(
    parameter int ROW_AW = 3
);
    logic              new_game;
    logic [24:0]       word_in;
    logic              key_valid;
    logic [4:0]        key_letter;
    logic              key_back;
    logic              key_enter;
    logic [34:0]       eval_row;
    logic [24:0]       eval_word;
    logic [34:0]       eval_result;
    logic              eval_done;
    logic [ROW_AW-1:0] rd_row;
    logic [34:0]       rd_data;
    logic [ROW_AW-1:0] cur_row;
    logic [2:0]        cur_col;
    logic              busy;
    logic              reject;
    logic              won;
    logic              lost;

    modport master (
        output new_game, word_in, key_valid, key_letter, key_back, key_enter,
               eval_result, eval_done, rd_row,
        input  eval_row, eval_word, rd_data, cur_row, cur_col, busy, reject, won, lost
    );

    modport slave (
        input  new_game, word_in, key_valid, key_letter, key_back, key_enter,
               eval_result, eval_done, rd_row,
        output eval_row, eval_word, rd_data, cur_row, cur_col, busy, reject, won, lost
    );
endinterface

// File: rtl/guess_row_sequencer.sv
// Game-level controller: builds guess rows from keystrokes, hands them to the colour
// evaluator, commits coloured rows to the board. Optional HARD_MODE_EN enforces greens.
module guess_row_sequencer #(
    parameter int MAX_ROWS = 6,
    parameter int ROW_AW   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    guess_row_sequencer_if.slave bus
);
    localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(MAX_ROWS - 1);
    localparam logic [ROW_AW:0]   NUM_ROWS = (ROW_AW + 1)'(MAX_ROWS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_EVAL,
        S_COMMIT,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [34:0]       row_q;
    logic [24:0]       secret_q;
    logic [2:0]        col_q;
    logic [ROW_AW-1:0] row_idx_q;
    logic [34:0]       board_q [MAX_ROWS];
    logic [34:0]       rd_q;
    logic              won_q;
    logic              lost_q;
    logic              reject_q;
    logic [34:0]       res_p1;
    logic              done_p1;

    logic do_clear, do_letter, do_back, do_reject, do_commit, do_win, do_lose, do_adv;
    logic hard_ok;
    logic rd_hit;
    logic [2:0] put_tile;
    logic [2:0] del_tile;

    assign put_tile = 3'd4 - col_q;
    assign del_tile = 3'd5 - col_q;
    assign rd_hit   = ({1'b0, bus.rd_row} < NUM_ROWS);

`ifdef HARD_MODE_EN
    logic [34:0] last_q;
    logic        last_vld_q;

    // Each green tile of the previous coloured row pins its letter in the new row.
    always_comb begin
        hard_ok = 1'b1;
        for (int t = 0; t < 5; t++) begin
            if (last_vld_q && last_q[7*t+5] && (last_q[7*t +: 5] != row_q[7*t +: 5]))
                hard_ok = 1'b0;
        end
    end
`else
    assign hard_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        do_clear  = 1'b0;
        do_letter = 1'b0;
        do_back   = 1'b0;
        do_reject = 1'b0;
        do_commit = 1'b0;
        do_win    = 1'b0;
        do_lose   = 1'b0;
        do_adv    = 1'b0;
        if (bus.new_game) begin
            do_clear = 1'b1;
            state_nx = S_ENTRY;
        end else begin
            case (state)
                S_ENTRY: begin
                    if (bus.key_enter) begin
                        if (col_q == 3'd5 && hard_ok)
                            state_nx = S_EVAL;
                        else
                            do_reject = 1'b1;
                    end else if (bus.key_back) begin
                        if (col_q != 3'd0)
                            do_back = 1'b1;
                        else
                            do_reject = 1'b1;
                    end else if (bus.key_valid) begin
                        if (col_q < 3'd5 && bus.key_letter <= 5'd25)
                            do_letter = 1'b1;
                        else
                            do_reject = 1'b1;
                    end
                end
                S_EVAL: state_nx = S_COMMIT;
                S_COMMIT: begin
                    do_commit = 1'b1;
                    if (done_p1) begin
                        do_win   = 1'b1;
                        state_nx = S_DONE;
                    end else if (row_idx_q == LAST_ROW) begin
                        do_lose  = 1'b1;
                        state_nx = S_DONE;
                    end else begin
                        do_adv   = 1'b1;
                        state_nx = S_ENTRY;
                    end
                end
                default: state_nx = state;
            endcase
        end
    end

    // Control, row and board state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q     <= '0;
            secret_q  <= '0;
            col_q     <= '0;
            row_idx_q <= '0;
            rd_q      <= '0;
            won_q     <= 1'b0;
            lost_q    <= 1'b0;
            reject_q  <= 1'b0;
            for (int r = 0; r < MAX_ROWS; r++)
                board_q[r] <= '0;
`ifdef HARD_MODE_EN
            last_vld_q <= 1'b0;
`endif
        end else begin
            reject_q <= do_reject;
            rd_q     <= rd_hit ? board_q[bus.rd_row] : '0;
            if (do_clear) begin
                row_q     <= '0;
                secret_q  <= bus.word_in;
                col_q     <= '0;
                row_idx_q <= '0;
                won_q     <= 1'b0;
                lost_q    <= 1'b0;
                for (int r = 0; r < MAX_ROWS; r++)
                    board_q[r] <= '0;
`ifdef HARD_MODE_EN
                last_vld_q <= 1'b0;
`endif
            end else begin
                if (do_letter)
                    col_q <= col_q + 3'd1;
                if (do_back)
                    col_q <= col_q - 3'd1;
                for (int t = 0; t < 5; t++) begin
                    if (do_letter && put_tile == 3'(t))
                        row_q[7*t +: 7] <= {2'b00, bus.key_letter};
                    if (do_back && del_tile == 3'(t))
                        row_q[7*t +: 7] <= '0;
                end
                if (do_commit)
                    board_q[row_idx_q] <= res_p1;
                if (do_win)
                    won_q <= 1'b1;
                if (do_lose)
                    lost_q <= 1'b1;
                if (do_adv) begin
                    row_idx_q <= row_idx_q + ROW_AW'(1);
                    col_q     <= '0;
                    row_q     <= '0;
                end
`ifdef HARD_MODE_EN
                if (do_commit)
                    last_vld_q <= 1'b1;
`endif
            end
        end
    end

    // Evaluator capture stage: result is only consumed in COMMIT, so no reset needed
    always_ff @(posedge clk) begin
        if (state == S_EVAL) begin
            res_p1  <= bus.eval_result;
            done_p1 <= bus.eval_done;
        end
`ifdef HARD_MODE_EN
        if (do_commit)
            last_q <= res_p1;
`endif
    end

    assign bus.eval_row  = row_q;
    assign bus.eval_word = secret_q;
    assign bus.rd_data   = rd_q;
    assign bus.cur_row   = row_idx_q;
    assign bus.cur_col   = col_q;
    assign bus.busy      = (state == S_EVAL) || (state == S_COMMIT);
    assign bus.reject    = reject_q;
    assign bus.won       = won_q;
    assign bus.lost      = lost_q;
endmodule
